// File: rtl/bitwise_lu_pkg.sv
// Shared opcode encoding and per-bit gate function for bitwise_logic_unit.
// The reduction output is enabled in the top by BITWISE_LU_REDUCE_EN.
package bitwise_lu_pkg;

   typedef enum logic [2:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_NOT  = 3'd2,
      OP_NAND = 3'd3,
      OP_NOR  = 3'd4,
      OP_XOR  = 3'd5,
      OP_XNOR = 3'd6,
      OP_PASS = 3'd7
   } op_e;

   localparam int OP_W  = 3;
   localparam int RED_W = 3;

   // One bit of the selected gate; the caller replicates it across the word.
   function automatic logic bit_op(input op_e op, input logic x, input logic y);
      logic r;
      case (op)
         OP_AND:  r = x & y;
         OP_OR:   r = x | y;
         OP_NOT:  r = ~x;
         OP_NAND: r = ~(x & y);
         OP_NOR:  r = ~(x | y);
         OP_XOR:  r = x ^ y;
         OP_XNOR: r = ~(x ^ y);
         OP_PASS: r = y;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/bitwise_lu_stage.sv
// Generic valid/ready register slice without skid buffer; RST_DATA selects
// whether the payload register is cleared by reset as well as the valid flag.
module bitwise_lu_stage #(
   parameter int DATA_W   = 8,
   parameter bit RST_DATA = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              up_valid,
   output logic              up_ready,
   input  logic [DATA_W-1:0] up_data,
   output logic              dn_valid,
   input  logic              dn_ready,
   output logic [DATA_W-1:0] dn_data
);

   logic              vld_p0;
   logic [DATA_W-1:0] data_p0;
   logic              load;

   // Ready depends combinationally on the downstream ready only.
   assign up_ready = !vld_p0 || dn_ready;
   assign load     = up_valid && up_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p0 <= 1'b0;
      end else begin
         vld_p0 <= load || (vld_p0 && !dn_ready);
      end
   end

   generate
      if (RST_DATA) begin : g_rst_data
         always_ff @(posedge clk) begin
            if (rst) begin
               data_p0 <= '0;
            end else if (load) begin
               data_p0 <= up_data;
            end
         end
      end else begin : g_free_data
         always_ff @(posedge clk) begin
            if (load) begin
               data_p0 <= up_data;
            end
         end
      end
   endgenerate

   assign dn_valid = vld_p0;
   assign dn_data  = data_p0;

endmodule

// File: rtl/bitwise_logic_unit.sv
// Two-stage pipelined bitwise gate unit with valid/ready on both sides and a
// completed-transaction counter; BITWISE_LU_REDUCE_EN adds the out_red port.
module bitwise_logic_unit
   import bitwise_lu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [OP_W-1:0]  op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [CNT_W-1:0] done_count
`ifdef BITWISE_LU_REDUCE_EN
   ,
   output logic [RED_W-1:0] out_red
`endif
);

   localparam int P1_W = OP_W + 2 * WIDTH;
`ifdef BITWISE_LU_REDUCE_EN
   localparam int P2_W = RED_W + WIDTH;
`else
   localparam int P2_W = WIDTH;
`endif

   logic [P1_W-1:0]  data_p0;
   logic [P1_W-1:0]  data_p1;
   logic             vld_p1;
   logic             rdy_p1;
   logic [OP_W-1:0]  op_p1;
   logic [WIDTH-1:0] a_p1;
   logic [WIDTH-1:0] b_p1;
   logic [WIDTH-1:0] res_p1;
   logic [P2_W-1:0]  data_p2_in;
   logic [P2_W-1:0]  data_p2;

   assign data_p0 = {op, a, b};

   // s1: register operands and opcode
   bitwise_lu_stage #(
      .DATA_W   (P1_W),
      .RST_DATA (1'b0)
   ) u_s1 (
      .clk      (clk),
      .rst      (rst),
      .up_valid (in_valid),
      .up_ready (in_ready),
      .up_data  (data_p0),
      .dn_valid (vld_p1),
      .dn_ready (rdy_p1),
      .dn_data  (data_p1)
   );

   assign {op_p1, a_p1, b_p1} = data_p1;

   always_comb begin
      res_p1 = '0;
      for (int i = 0; i < WIDTH; i++) begin
         res_p1[i] = bit_op(op_e'(op_p1), a_p1[i], b_p1[i]);
      end
   end

`ifdef BITWISE_LU_REDUCE_EN
   assign data_p2_in = {^res_p1, |res_p1, &res_p1, res_p1};
`else
   assign data_p2_in = res_p1;
`endif

   // s2: register computed result (payload cleared on reset)
   bitwise_lu_stage #(
      .DATA_W   (P2_W),
      .RST_DATA (1'b1)
   ) u_s2 (
      .clk      (clk),
      .rst      (rst),
      .up_valid (vld_p1),
      .up_ready (rdy_p1),
      .up_data  (data_p2_in),
      .dn_valid (out_valid),
      .dn_ready (out_ready),
      .dn_data  (data_p2)
   );

`ifdef BITWISE_LU_REDUCE_EN
   assign {out_red, result} = data_p2;
`else
   assign result = data_p2;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         done_count <= '0;
      end else if (out_valid && out_ready) begin
         done_count <= done_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Scoreboard bench for bitwise_logic_unit; build with BITWISE_LU_REDUCE_EN
// defined to also exercise the out_red port.
module tb_bitwise_logic_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] a;
   logic [7:0] b;
   logic [2:0] op;
   logic       out_ready;

   logic        in_ready, out_valid;
   logic [7:0]  result;
   logic [15:0] done_count;
   logic        in_ready_w, out_valid_w;
   logic [7:0]  result_w;
   logic [1:0]  done_count_w;
`ifdef BITWISE_LU_REDUCE_EN
   logic [2:0]  out_red, out_red_w;
`endif

   int checks = 0;
   int errors = 0;
   logic [7:0] sb[$];
   logic       prev_stall = 1'b0;
   logic [7:0] prev_result;

   always #5 clk = ~clk;

   bitwise_logic_unit #(.WIDTH(8), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .done_count(done_count)
`ifdef BITWISE_LU_REDUCE_EN
      , .out_red(out_red)
`endif
   );

   bitwise_logic_unit #(.WIDTH(8), .CNT_W(2)) dut_w (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
      .a(a), .b(b), .op(op), .out_valid(out_valid_w), .out_ready(out_ready),
      .result(result_w), .done_count(done_count_w)
`ifdef BITWISE_LU_REDUCE_EN
      , .out_red(out_red_w)
`endif
   );

   function automatic logic [7:0] model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
      case (o)
         3'd0: return x & y;
         3'd1: return x | y;
         3'd2: return ~x;
         3'd3: return ~(x & y);
         3'd4: return ~(x | y);
         3'd5: return x ^ y;
         3'd6: return ~(x ^ y);
         default: return y;
      endcase
   endfunction

   // Scoreboard: push on accepted input, pop on output handshake, check holds.
   always @(negedge clk) begin
      if (rst !== 1'b0) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            checks++;
            if (out_valid !== 1'b1 || result !== prev_result) begin
               errors++;
               $display("FAIL stall_hold: out_valid=%b result=%h required out_valid=1 result=%h",
                        out_valid, result, prev_result);
            end
         end
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_output: result=%h with empty scoreboard", result);
            end else begin
               logic [7:0] e;
               e = sb.pop_front();
               if (result !== e) begin
                  errors++;
                  $display("FAIL sb_result: got %h required %h", result, e);
               end
            end
         end
         prev_stall  = (out_valid === 1'b1 && out_ready === 1'b0);
         prev_result = result;
         if (in_valid === 1'b1 && in_ready === 1'b1) sb.push_back(model(op, a, b));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      sb.delete();
      repeat (2) tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || result !== 8'h00 || done_count !== 16'd0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_state: out_valid=%b result=%h done_count=%0d in_ready=%b required 0,00,0,1",
                  out_valid, result, done_count, in_ready);
      end
      tick();
   endtask

   task automatic test_truth_sweep();
      logic [7:0] exp_t [8] = '{8'hC0, 8'hFC, 8'h0F, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'hCC};
      do_reset();
      out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         if (c < 8) begin
            in_valid = 1'b1; a = 8'hF0; b = 8'hCC; op = 3'(c);
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         checks++;
         if (out_valid !== (c >= 2)) begin
            errors++;
            $display("FAIL sweep_valid cycle %0d: out_valid=%b required %b", c, out_valid, (c >= 2));
         end else if (c >= 2 && result !== exp_t[c-2]) begin
            errors++;
            $display("FAIL sweep_result op %0d: got %h required %h", c - 2, result, exp_t[c-2]);
         end
         tick();
      end
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (done_count !== 16'd8 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL sweep_count: done_count=%0d out_valid=%b required 8,0", done_count, out_valid);
      end
      tick();
   endtask

   task automatic test_backpressure();
      int sent;
      logic acc;
      logic [7:0] first;
      do_reset();
      sent = 0;
      out_ready = 1'b0;
      in_valid = 1'b1; a = 8'h5A; b = 8'h0F; op = 3'd5;
      first = model(3'd5, 8'h5A, 8'h0F);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         acc = in_valid && in_ready;
         tick();
         if (acc) begin
            sent++;
            a = a + 8'h11; b = b ^ 8'h3C; op = op + 3'd1;
            in_valid = (sent < 3);
         end
      end
      @(negedge clk);
      checks++;
      if (sent != 2 || in_ready !== 1'b0 || out_valid !== 1'b1 || result !== first) begin
         errors++;
         $display("FAIL bp_full: sent=%0d in_ready=%b out_valid=%b result=%h required 2,0,1,%h",
                  sent, in_ready, out_valid, result, first);
      end
      tick();
      out_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         acc = in_valid && in_ready;
         tick();
         if (acc) begin
            sent++;
            in_valid = (sent < 3);
         end
      end
      checks++;
      if (sent != 3 || sb.size() != 0 || done_count !== 16'd3) begin
         errors++;
         $display("FAIL bp_drain: sent=%0d pending=%0d done_count=%0d required 3,0,3",
                  sent, sb.size(), done_count);
      end
   endtask

   task automatic test_counter_wrap();
      logic [1:0] exp_w [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      logic [1:0] last;
      int idx;
      do_reset();
      last = 2'd0;
      idx = 0;
      out_ready = 1'b1;
      in_valid = 1'b1; a = 8'h33; b = 8'h55; op = 3'd1;
      for (int c = 0; c < 15; c++) begin
         if (c == 5) in_valid = 1'b0;
         @(negedge clk);
         if (done_count_w !== last) begin
            checks++;
            if (idx >= 5 || done_count_w !== exp_w[idx]) begin
               errors++;
               $display("FAIL wrap_step %0d: done_count=%0d required %0d", idx, done_count_w,
                        (idx < 5) ? exp_w[idx] : 2'd0);
            end
            last = done_count_w;
            idx++;
         end
         tick();
      end
      checks++;
      if (idx != 5) begin
         errors++;
         $display("FAIL wrap_total: handshakes seen %0d required 5", idx);
      end
   endtask

   task automatic test_reset_midflight();
      int stale;
      do_reset();
      out_ready = 1'b0;
      in_valid = 1'b1; a = 8'hAA; b = 8'h0F; op = 3'd0;
      tick();
      a = 8'h12; op = 3'd6;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL mid_prefill: out_valid=%b required 1", out_valid);
      end
      tick();
      rst = 1'b1;
      sb.delete();
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_flush: out_valid=%b required 0", out_valid);
      end
      rst = 1'b0;
      out_ready = 1'b1;
      stale = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (out_valid !== 1'b0) stale++;
         tick();
      end
      checks++;
      if (stale != 0) begin
         errors++;
         $display("FAIL mid_stale: %0d stale output cycles required 0", stale);
      end
   endtask

`ifdef BITWISE_LU_REDUCE_EN
   task automatic test_reduce();
      do_reset();
      out_ready = 1'b1;
      in_valid = 1'b1; a = 8'hFF; b = 8'h00; op = 3'd5;
      tick();
      a = 8'h01; b = 8'h01; op = 3'd0;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (result !== 8'hFF || out_red !== 3'b011) begin
         errors++;
         $display("FAIL red_xor: result=%h out_red=%b required ff 011", result, out_red);
      end
      tick();
      @(negedge clk);
      checks++;
      if (result !== 8'h01 || out_red !== 3'b110) begin
         errors++;
         $display("FAIL red_and: result=%h out_red=%b required 01 110", result, out_red);
      end
      tick();
   endtask
`endif

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      a = '0;
      b = '0;
      op = '0;
      out_ready = 1'b1;
      test_reset();
      test_truth_sweep();
      test_backpressure();
      test_counter_wrap();
      test_reset_midflight();
`ifdef BITWISE_LU_REDUCE_EN
      test_reduce();
`endif
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: %0d results never produced", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
